// File: rtl/mux_4_rr_arbiter_if.sv
// Bundle of request, data and output-handshake signals shared between the
// four producers, the round-robin arbiter and the downstream 32-bit consumer.
// The master modport is the arbiter side; the slave modport is the side that
// drives requests and data and accepts the output word.
interface mux_4_rr_arbiter_if;
    logic [3:0]  req;
    logic [31:0] i0;
    logic [15:0] i1;
    logic [31:0] i2;
    logic [7:0]  i3;
    logic [3:0]  ack;
    logic [1:0]  grant;
    logic [31:0] o;
    logic        o_valid;
    logic        o_ready;
    logic        timeout;

    modport master (
        input  req, i0, i1, i2, i3, o_ready,
        output ack, grant, o, o_valid, timeout
    );

    modport slave (
        output req, i0, i1, i2, i3, o_ready,
        input  ack, grant, o, o_valid, timeout
    );
endinterface

// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared, registered 32-bit 4:1 output
// path. Sources are 32, 16, 32 and 8 bits wide and are zero-extended on capture.
// A held word waits for o_ready and is dropped after TIMEOUT cycles (0 = never).
// Optional build macro MUX_4_RR_ARBITER_STATS_EN adds per-source 16-bit
// saturating consumed-word counters (stats) and a saturating drop count (drops).
module mux_4_rr_arbiter #(
    parameter int TIMEOUT   = 16,
    parameter int RESET_PTR = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    mux_4_rr_arbiter_if.master   bus
`ifdef MUX_4_RR_ARBITER_STATS_EN
    ,
    output logic [63:0]          stats,
    output logic [7:0]           drops
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam logic [1:0] PTR_INIT     = 2'(RESET_PTR);

    state_t      state;
    state_t      next_state;
    logic [1:0]  ptr;
    logic [7:0]  wait_cnt;
    logic [1:0]  winner;
    logic [1:0]  scan_idx;
    logic        found;
    logic [31:0] winner_data;
    logic        capture;
    logic        go_idle;
    logic        drop;
    logic        count;

    // Scan req starting at ptr and pick the first requesting source.
    always_comb begin
        winner   = ptr;
        scan_idx = ptr;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!found && bus.req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Zero-extend the winning source onto the 32-bit path.
    always_comb begin
        winner_data = 32'd0;
        case (winner)
            2'd0:    winner_data = bus.i0;
            2'd1:    winner_data = {16'd0, bus.i1};
            2'd2:    winner_data = bus.i2;
            default: winner_data = {24'd0, bus.i3};
        endcase
    end

    // Next-state and action decode: capture, release, drop on timeout, or keep waiting.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        go_idle    = 1'b0;
        drop       = 1'b0;
        count      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            default: begin
                if (bus.o_ready) begin
                    if (found) begin
                        capture = 1'b1;
                    end else begin
                        go_idle    = 1'b1;
                        next_state = IDLE;
                    end
                end else if (TIMEOUT != 0 && wait_cnt == TIMEOUT_LAST) begin
                    drop       = 1'b1;
                    next_state = IDLE;
                end else begin
                    count = 1'b1;
                end
            end
        endcase
    end

    // State, output word, pointer, wait counter and one-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bus.o       <= 32'd0;
            bus.o_valid <= 1'b0;
            bus.grant   <= 2'd0;
            bus.ack     <= 4'd0;
            bus.timeout <= 1'b0;
            ptr         <= PTR_INIT;
            wait_cnt    <= 8'd0;
        end else begin
            state       <= next_state;
            bus.ack     <= 4'd0;
            bus.timeout <= 1'b0;
            if (capture) begin
                bus.o       <= winner_data;
                bus.grant   <= winner;
                bus.o_valid <= 1'b1;
                bus.ack     <= 4'b0001 << winner;
                ptr         <= winner + 2'd1;
                wait_cnt    <= 8'd0;
            end else if (go_idle) begin
                bus.o_valid <= 1'b0;
            end else if (drop) begin
                bus.o_valid <= 1'b0;
                bus.timeout <= 1'b1;
                wait_cnt    <= 8'd0;
            end else if (count) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

`ifdef MUX_4_RR_ARBITER_STATS_EN
    logic consumed;
    assign consumed = bus.o_valid & bus.o_ready;

    // Saturating per-source consumed counters and saturating drop counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            stats <= 64'd0;
            drops <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (consumed && bus.grant == 2'(k) && stats[16*k +: 16] != 16'hFFFF) begin
                    stats[16*k +: 16] <= stats[16*k +: 16] + 16'd1;
                end
            end
            if (drop && drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Self-checking bench for mux_4_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle with a transaction-level
// reference model of the arbiter.
module tb_mux_4_rr_arbiter;

    localparam int TIMEOUT   = 16;
    localparam int RESET_PTR = 0;

    logic clock;
    logic reset;
    mux_4_rr_arbiter_if bus ();
`ifdef MUX_4_RR_ARBITER_STATS_EN
    logic [63:0] stats;
    logic [7:0]  drops;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers and flags.
    bit          m_valid;
    logic [31:0] m_o;
    int          m_grant;
    int          m_ptr;
    int          m_wait;
    logic [3:0]  m_ack;
    bit          m_to;
    int          m_stats [4];
    int          m_drops;

    mux_4_rr_arbiter #(.TIMEOUT(TIMEOUT), .RESET_PTR(RESET_PTR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
`ifdef MUX_4_RR_ARBITER_STATS_EN
        ,
        .stats (stats),
        .drops (drops)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge given the inputs now on the bus.
    task automatic predictModel();
        int w;
        logic [31:0] data;
        bit consumed;
        consumed = m_valid && bus.o_ready;
        m_ack = 4'd0;
        m_to  = 1'b0;
        if (reset) begin
            m_valid = 0; m_o = 0; m_grant = 0; m_ptr = RESET_PTR; m_wait = 0;
            for (int k = 0; k < 4; k++) m_stats[k] = 0;
            m_drops = 0;
            return;
        end
        if (consumed && m_stats[m_grant] < 65535) m_stats[m_grant]++;
        w = -1;
        if ((!m_valid || bus.o_ready) && bus.req != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
        end
        if (w >= 0) begin
            case (w)
                0: data = bus.i0;
                1: data = 32'(bus.i1);
                2: data = bus.i2;
                default: data = 32'(bus.i3);
            endcase
            m_o = data; m_grant = w; m_valid = 1; m_ack = 4'(1 << w);
            m_ptr = (w + 1) % 4; m_wait = 0;
        end else if (m_valid && bus.o_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            if (TIMEOUT != 0 && m_wait == TIMEOUT - 1) begin
                m_valid = 0; m_to = 1; m_wait = 0;
                if (m_drops < 255) m_drops++;
            end else begin
                m_wait++;
            end
        end
    endtask

    // Compare every visible DUT output against the model.
    task automatic compareAll();
        checkOutput("o_valid", 64'(bus.o_valid), 64'(m_valid));
        checkOutput("o", 64'(bus.o), 64'(m_o));
        checkOutput("grant", 64'(bus.grant), 64'(m_grant));
        checkOutput("ack", 64'(bus.ack), 64'(m_ack));
        checkOutput("timeout", 64'(bus.timeout), 64'(m_to));
`ifdef MUX_4_RR_ARBITER_STATS_EN
        checkOutput("stats", stats, {16'(m_stats[3]), 16'(m_stats[2]), 16'(m_stats[1]), 16'(m_stats[0])});
        checkOutput("drops", 64'(drops), 64'(m_drops));
`endif
    endtask

    // Drive one cycle of inputs, step the model, clock, then check.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] d0,
                                 input logic [15:0] d1, input logic [31:0] d2,
                                 input logic [7:0] d3, input logic rdy);
        reset = r; bus.req = rq; bus.i0 = d0; bus.i1 = d1; bus.i2 = d2; bus.i3 = d3;
        bus.o_ready = rdy;
        predictModel();
        @(posedge clock);
        #1;
        compareAll();
    endtask

    int grant_seq [5] = '{0, 1, 2, 3, 0};
    int ready_pct;

    initial begin
        reset = 1'b1; bus.req = 4'd0; bus.i0 = 0; bus.i1 = 0; bus.i2 = 0; bus.i3 = 0;
        bus.o_ready = 1'b0;
        m_valid = 0; m_o = 0; m_grant = 0; m_ptr = RESET_PTR; m_wait = 0; m_drops = 0;
        for (int k = 0; k < 4; k++) m_stats[k] = 0;

        // Reset, then idle with no requests.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 4'b0000, 32'hDEADBEEF, 16'h1111, 32'h2222, 8'h33, 1);
            checkOutput("idle_o_valid", 64'(bus.o_valid), 64'd0);
            checkOutput("idle_o", 64'(bus.o), 64'd0);
        end

        // Single 16-bit transfer, zero-extended.
        applyStimulus(0, 4'b0010, 0, 16'hBEEF, 0, 0, 1);
        checkOutput("beef_o", 64'(bus.o), 64'h0000BEEF);
        checkOutput("beef_grant", 64'(bus.grant), 64'd1);
        checkOutput("beef_ack", 64'(bus.ack), 64'b0010);
        applyStimulus(0, 4'b0000, 0, 16'hBEEF, 0, 0, 1);
        checkOutput("beef_drop_valid", 64'(bus.o_valid), 64'd0);
        checkOutput("beef_ack_gone", 64'(bus.ack), 64'd0);

        // All four requesting back to back.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 4'b1111, 32'hAAAA0000, 16'hBBBB, 32'hCCCC0000, 8'hA5, 1);
            checkOutput("rr_grant", 64'(bus.grant), 64'(grant_seq[c]));
            checkOutput("rr_valid", 64'(bus.o_valid), 64'd1);
            if (grant_seq[c] == 3) checkOutput("rr_o3", 64'(bus.o), 64'h000000A5);
        end

        // Held word times out after TIMEOUT cycles without o_ready.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0001, 32'h12345678, 0, 0, 0, 0);
        checkOutput("to_capture_o", 64'(bus.o), 64'h12345678);
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
            checkOutput("to_hold_valid", 64'(bus.o_valid), 64'd1);
            checkOutput("to_no_pulse", 64'(bus.timeout), 64'd0);
        end
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
        checkOutput("to_pulse", 64'(bus.timeout), 64'd1);
        checkOutput("to_valid_low", 64'(bus.o_valid), 64'd0);
        applyStimulus(0, 4'b1111, 1, 2, 3, 4, 1);
        checkOutput("to_next_grant", 64'(bus.grant), 64'd1);

        // Reset while holding an unconsumed word.
        applyStimulus(0, 4'b0100, 0, 0, 32'hCAFEF00D, 0, 0);
        applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
        checkOutput("rst_hold_valid", 64'(bus.o_valid), 64'd0);
        checkOutput("rst_hold_o", 64'(bus.o), 64'd0);
        checkOutput("rst_hold_ack", 64'(bus.ack), 64'd0);
        checkOutput("rst_hold_to", 64'(bus.timeout), 64'd0);
        applyStimulus(0, 4'b1111, 1, 2, 3, 4, 1);
        checkOutput("rst_ptr_grant", 64'(bus.grant), 64'(RESET_PTR));

`ifdef MUX_4_RR_ARBITER_STATS_EN
        // Three consumed words from source 2 and one dropped word from source 0.
        applyStimulus(1, 4'b0000, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 4'b0100, 0, 0, 32'h100 + c, 0, 1);
            applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 4'b0001, 32'h77, 0, 0, 0, 0);
        for (int c = 0; c < TIMEOUT; c++) applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
        checkOutput("stats_src2", 64'(stats[47:32]), 64'd3);
        checkOutput("stats_src0", 64'(stats[15:0]), 64'd0);
        checkOutput("stats_drops", 64'(drops), 64'd1);
`endif

        // Randomized traffic with varying consumer readiness.
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: ready_pct = 0;
                    1: ready_pct = 30;
                    2: ready_pct = 70;
                    default: ready_pct = 100;
                endcase
            end
            applyStimulus(($urandom_range(0, 199) == 0),
                          4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'd0 : 4'hF),
                          $urandom, 16'($urandom), $urandom, 8'($urandom),
                          ($urandom_range(0, 99) < ready_pct));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_4_rr_arbiter.md
Name: mux_4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered 32-bit 4:1 output path between four requesters of mixed widths: 32, 16, 32 and 8 bits.
- Captures the granted source, zero-extends it to 32 bits and presents it on a valid/ready output port.
- Sits between the producer blocks and the downstream 32-bit consumer, and replaces free-running select control of the shared mux.

Parameters:
- TIMEOUT, default 16: cycles an output word may wait for o_ready before it is dropped. 0 disables the timeout. Legal range is 0..255.
- RESET_PTR, default 0: round-robin pointer value after reset, range 0..3.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  4  per-source request; bit k requests transfer of source k
- i0  input  32  source 0 data
- i1  input  16  source 1 data, zero-extended
- i2  input  32  source 2 data
- i3  input  8  source 3 data, zero-extended
- ack  output  4  one-hot, one-cycle pulse on the cycle source k's data is captured
- grant  output  2  index of the source currently held on o
- o  output  32  registered output word
- o_valid  output  1  o holds an unconsumed word
- o_ready  input  1  consumer accepts o this cycle when o_valid=1
- timeout  output  1  one-cycle pulse when a held word is dropped

Behaviour:
- Reset (reset=1 at a clock edge) wins over everything else. It sets: state=IDLE, o=0, o_valid=0, grant=0, ack=0, timeout=0, ptr=RESET_PTR, wait counter=0. Reset during HOLD discards the held word and raises no ack or timeout.
- States: IDLE and HOLD.
- Selection: the winner is the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3, taken mod 4.
- Capture rule (all registered, at one edge):
  - o <= zero-extended data of the winner; grant <= winner; o_valid <= 1.
  - ack <= one-hot of the winner for exactly one cycle; ptr <= winner+1 mod 4.
  - The wait counter clears.
- IDLE:
  - If req != 0, capture and go to HOLD.
  - Otherwise stay in IDLE, with o and grant holding their last values and o_valid=0.
- HOLD:
  - o_ready=1, req != 0: the word is consumed and the next winner is captured at the same edge. This gives 100% throughput and no bubble.
  - o_ready=1, req == 0: o_valid <= 0 and go to IDLE.
  - o_ready=0 with TIMEOUT != 0 and wait counter == TIMEOUT-1: o_valid <= 0, timeout pulses for 1 cycle, go to IDLE. ptr was already advanced at capture.
  - o_ready=0 otherwise: hold o and grant stable and increment the wait counter.
- Latency: req sampled at edge N gives o_valid=1 and ack after edge N, i.e. in cycle N+1.
- Requester contract: a requester keeps req and its data stable until it sees ack. Data after ack is ignored until the next grant. A requester may hold req high continuously; it is then granted at most once per 4 captures while others are requesting.
- The timeout is evaluated only when o_ready=0. If o_ready rises on the timeout cycle, the transfer completes normally.
- ack is never asserted when no capture occurs. At most one ack bit is set in any cycle.
- Zero-extension is exact: o[31:16]=0 for source 1 and o[31:8]=0 for source 3.

Optional Feature:
- Macro: MUX_4_RR_ARBITER_STATS_EN.
- When defined:
  - Adds output stats (64 bits) holding four 16-bit saturating counters; source k occupies stats[16k+15:16k].
  - A counter increments when source k's word is consumed (o_valid & o_ready with grant=k). It saturates at 16'hFFFF and is cleared by reset.
  - Adds output drops (8 bits), a saturating count of timeout pulses.
- When undefined: neither port nor the counter logic exists. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> o_valid=0, ack=0, o=0, grant=0 throughout.
- req=4'b0010, i1=16'hBEEF, o_ready=1 -> the next cycle shows o=32'h0000BEEF, grant=1, ack=4'b0010 for 1 cycle. o_valid then drops because no further req.
- All four req held high, o_ready=1, RESET_PTR=0, i3=8'hA5 -> grant sequence 0,1,2,3,0 on consecutive cycles with o_valid continuously 1. When grant=3, o=32'h000000A5.
- req=4'b0001, i0=32'h12345678, o_ready=0, TIMEOUT=16 -> o held for 16 cycles, then timeout pulses once, o_valid=0, and the next grant starts the scan at source 1.
- Assert reset in the HOLD state while o_ready=0 -> the next cycle shows o_valid=0, o=0, ptr=RESET_PTR, and no ack or timeout pulse.
- With MUX_4_RR_ARBITER_STATS_EN defined, 3 consumed transfers from source 2 and 1 timeout from source 0 -> stats[47:32]=3, stats[15:0]=0, drops=1.
